nes_clock_sched: RTL and testbench

Clock-enable scheduler for the NES core, running on the MMCM master clock output `clk_mst` (~21.477 MHz). It gates startup on MMCM lock and derives the single-cycle PPU and CPU clock enables from one shared master-cycle counter, keeping them phase-locked. It also generates the CPU M2 phase and provides debug pause and single-step control. CPU, PPU and APU logic on `clk_mst` use only these enables and never a derived clock.

---
 rtl/nes_clock_sched.sv | 205 ++++++++++++++++++++
 tb/tb_nes_clock_sched.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nes_clock_sched.sv
// ---------------------------------------------------------------------------
// nes_clock_sched
//
// Clock-enable scheduler for the NES core on the MMCM master clock.
// Startup waits for MMCM lock.
// One master-cycle counter (mc) produces the PPU and CPU clock enables, so
// the two enables can never drift apart.
// The block also produces the CPU M2 phase and a debug pause/single-step
// facility.
//
// Optional feature macro: NES_DEBUG_STEP_EN
//   defined   -> PAUSED and STEP states exist; run / step_req / step_ack live
//   undefined -> run and step_req ignored, step_ack tied 0, startup always
//                exits straight to free-running
//
// Ports:
//   clk_mst     in   master clock (only clock in the block)
//   rst         in   synchronous active-high reset
//   pll_locked  in   MMCM lock, asynchronous, synchronized internally
//   run         in   1 = free-run, 0 = pause at next CPU-period boundary
//   step_req    in   pulse: while paused, run exactly one CPU period
//   step_ack    out  pulse in the first paused cycle after a completed step
//   ce_ppu      out  PPU clock enable (one master cycle wide)
//   ce_cpu      out  CPU clock enable (one master cycle wide)
//   m2          out  CPU M2 phase level
//   cpu_cycles  out  number of ce_cpu pulses issued, wraps modulo 2^32
// ---------------------------------------------------------------------------
module nes_clock_sched #(
    parameter int PPU_DIV        = 4,
    parameter int CPU_DIV        = 12,
    parameter int CPU_PHASE      = 0,
    parameter int M2_LOW         = 5,
    parameter int STARTUP_CYCLES = 16
) (
    input  logic        clk_mst,
    input  logic        rst,
    input  logic        pll_locked,
    input  logic        run,
    input  logic        step_req,
    output logic        step_ack,
    output logic        ce_ppu,
    output logic        ce_cpu,
    output logic        m2,
    output logic [31:0] cpu_cycles
);

    localparam int MC_W = (CPU_DIV > 1) ? $clog2(CPU_DIV) : 1;
    localparam int SU_W = $clog2(STARTUP_CYCLES + 1);

    // The RESET_WAIT cycle that first sees lock_s high counts as the first
    // wait cycle.
    // STARTUP therefore lasts STARTUP_CYCLES-1 cycles.
    // This makes pll_locked-to-first-RUN exactly 2 + STARTUP_CYCLES clocks.
    localparam int SU_EXIT = (STARTUP_CYCLES > 2) ? STARTUP_CYCLES - 2 : 0;

    localparam logic [MC_W-1:0] MC_LAST = MC_W'(CPU_DIV - 1);

    typedef enum logic [2:0] {
        ST_RESET_WAIT = 3'd0,
        ST_STARTUP    = 3'd1,
        ST_RUN        = 3'd2,
        ST_PAUSED     = 3'd3,
        ST_STEP       = 3'd4
    } state_t;

    state_t          state;
    state_t          nxt_state;
    logic [MC_W-1:0] mc;
    logic [MC_W-1:0] nxt_mc;
    logic [SU_W-1:0] su_cnt;
    logic [SU_W-1:0] nxt_su;
    logic            lock_meta;
    logic            lock_s;
    logic            nxt_counting;
    logic            ppu_hit;
    logic            cpu_hit;
    logic            m2_calc;
    logic [31:0]     m2_off;
    logic            step_done;

`ifndef NES_DEBUG_STEP_EN
    logic unused_debug_inputs;
    assign unused_debug_inputs = run ^ step_req;
`endif

    // Next state and next counter value.
    // The outputs are registered from these values, so each output matches
    // the state and mc of the same cycle.
    // Losing lock takes priority over every state.
    always_comb begin
        nxt_state = state;
        nxt_mc    = mc;
        nxt_su    = su_cnt;
        step_done = 1'b0;
        if (!lock_s) begin
            nxt_state = ST_RESET_WAIT;
            nxt_mc    = '0;
            nxt_su    = '0;
        end else begin
            case (state)
                ST_RESET_WAIT: begin
                    nxt_state = ST_STARTUP;
                    nxt_mc    = '0;
                    nxt_su    = '0;
                end
                ST_STARTUP: begin
                    if (su_cnt == SU_W'(SU_EXIT)) begin
                        nxt_mc = '0;
`ifdef NES_DEBUG_STEP_EN
                        nxt_state = run ? ST_RUN : ST_PAUSED;
`else
                        nxt_state = ST_RUN;
`endif
                    end else begin
                        nxt_su = su_cnt + SU_W'(1);
                    end
                end
                ST_RUN: begin
                    // A pause request only takes effect at the period
                    // boundary, so the current CPU period always completes.
                    if (mc == MC_LAST) begin
                        nxt_mc = '0;
`ifdef NES_DEBUG_STEP_EN
                        if (!run) nxt_state = ST_PAUSED;
`endif
                    end else begin
                        nxt_mc = mc + MC_W'(1);
                    end
                end
`ifdef NES_DEBUG_STEP_EN
                ST_PAUSED: begin
                    if (run)           nxt_state = ST_RUN;
                    else if (step_req) nxt_state = ST_STEP;
                end
                ST_STEP: begin
                    if (mc == MC_LAST) begin
                        nxt_mc    = '0;
                        nxt_state = ST_PAUSED;
                        step_done = 1'b1;
                    end else begin
                        nxt_mc = mc + MC_W'(1);
                    end
                end
`endif
                default: begin
                    nxt_state = ST_RESET_WAIT;
                    nxt_mc    = '0;
                    nxt_su    = '0;
                end
            endcase
        end
    end

    // Enable and M2 decode from the upcoming mc.
    // The M2 offset is measured from the ce_cpu position.
    // M2 is low for the first M2_LOW cycles of that offset.
    always_comb begin
        nxt_counting = (nxt_state == ST_RUN) || (nxt_state == ST_STEP);
        ppu_hit      = (32'(nxt_mc) % 32'(PPU_DIV)) == 32'd0;
        cpu_hit      = (nxt_mc == MC_W'(CPU_PHASE));
        m2_off       = (32'(nxt_mc) + 32'(CPU_DIV - CPU_PHASE)) % 32'(CPU_DIV);
        m2_calc      = (m2_off >= 32'(M2_LOW));
    end

    // The state register, lock synchronizer and all registered outputs.
    // In PAUSED, m2 keeps its last level.
    // In RESET_WAIT and STARTUP, m2 is driven low.
    always_ff @(posedge clk_mst) begin
        if (rst) begin
            lock_meta  <= 1'b0;
            lock_s     <= 1'b0;
            state      <= ST_RESET_WAIT;
            mc         <= '0;
            su_cnt     <= '0;
            ce_ppu     <= 1'b0;
            ce_cpu     <= 1'b0;
            m2         <= 1'b0;
            cpu_cycles <= 32'd0;
        end else begin
            lock_meta  <= pll_locked;
            lock_s     <= lock_meta;
            state      <= nxt_state;
            mc         <= nxt_mc;
            su_cnt     <= nxt_su;
            ce_ppu     <= nxt_counting && ppu_hit;
            ce_cpu     <= nxt_counting && cpu_hit;
            cpu_cycles <= cpu_cycles + {31'd0, nxt_counting && cpu_hit};
            if (nxt_counting)                m2 <= m2_calc;
            else if (nxt_state != ST_PAUSED) m2 <= 1'b0;
        end
    end

`ifdef NES_DEBUG_STEP_EN
    // step_ack fires only when a step runs to completion.
    // If lock is lost during a step, the next state is RESET_WAIT rather
    // than PAUSED, so no acknowledge is produced.
    always_ff @(posedge clk_mst) begin
        if (rst) step_ack <= 1'b0;
        else     step_ack <= step_done;
    end
`else
    assign step_ack = 1'b0;
`endif

endmodule

// File: tb/tb_nes_clock_sched.sv
module tb_nes_clock_sched;

    localparam int PPU_DIV        = 4;
    localparam int CPU_DIV        = 12;
    localparam int M2_LOW         = 5;
    localparam int STARTUP_CYCLES = 16;
`ifdef NES_DEBUG_STEP_EN
    localparam bit DEBUG = 1'b1;
`else
    localparam bit DEBUG = 1'b0;
`endif

    logic        clk_mst = 1'b0;
    logic        rst = 1'b1;
    logic        pll_locked = 1'b0;
    logic        run = 1'b1;
    logic        step_req = 1'b0;
    logic [1:0]  step_ack_v;
    logic [1:0]  ce_ppu_v;
    logic [1:0]  ce_cpu_v;
    logic [1:0]  m2_v;
    logic [31:0] cyc_v [2];

    always #5 clk_mst = ~clk_mst;

    nes_clock_sched dut0 (
        .clk_mst(clk_mst), .rst(rst), .pll_locked(pll_locked), .run(run),
        .step_req(step_req), .step_ack(step_ack_v[0]), .ce_ppu(ce_ppu_v[0]),
        .ce_cpu(ce_cpu_v[0]), .m2(m2_v[0]), .cpu_cycles(cyc_v[0])
    );

    nes_clock_sched #(.CPU_PHASE(6)) dut6 (
        .clk_mst(clk_mst), .rst(rst), .pll_locked(pll_locked), .run(run),
        .step_req(step_req), .step_ack(step_ack_v[1]), .ce_ppu(ce_ppu_v[1]),
        .ce_cpu(ce_cpu_v[1]), .m2(m2_v[1]), .cpu_cycles(cyc_v[1])
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc_no = 0;

    // Reference model.
    // mode: 0 = waiting for lock / startup, 1 = free run, 2 = paused,
    //       3 = stepping.
    // age counts clocks with synchronized lock high.
    int          m_mode = 0;
    int          m_pos = 0;
    int          m_age = 0;
    bit          m_s1 = 0;
    bit          m_ls = 0;
    bit          m_ack = 0;
    bit          m_ppu = 0;
    bit          m_cpu [2];
    bit          m_m2 [2];
    logic [31:0] m_cyc [2];
    int          phase [2] = '{0, 6};

    // Observation statistics
    int n_ppu0 = 0, n_cpu0 = 0, n_cpu1 = 0, n_m2low0 = 0, n_ack = 0;
    int last_ack = -1, first_ce = -1, first_ppu = -1;
    int since0 = 1000, ph_bad = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc_no);
        end
    endtask

    task automatic model_update();
        bit old_ls;
        bit counting;
        if (rst) begin
            m_s1 = 0; m_ls = 0; m_age = 0; m_mode = 0; m_pos = 0; m_ack = 0; m_ppu = 0;
            for (int i = 0; i < 2; i++) begin
                m_cpu[i] = 0; m_m2[i] = 0; m_cyc[i] = 32'd0;
            end
        end else begin
            old_ls = m_ls;
            m_ls   = m_s1;
            m_s1   = pll_locked;
            m_ack  = 0;
            if (!old_ls) begin
                m_age = 0; m_mode = 0; m_pos = 0;
            end else if (m_mode == 0) begin
                m_age++;
                if (m_age == STARTUP_CYCLES) begin
                    m_mode = (DEBUG && !run) ? 2 : 1;
                    m_pos  = 0;
                end
            end else if (m_mode == 1) begin
                m_pos = (m_pos + 1) % CPU_DIV;
                if (m_pos == 0 && DEBUG && !run) m_mode = 2;
            end else if (m_mode == 2) begin
                if (run)           m_mode = 1;
                else if (step_req) m_mode = 3;
            end else begin
                m_pos = (m_pos + 1) % CPU_DIV;
                if (m_pos == 0) begin
                    m_mode = 2;
                    m_ack  = 1;
                end
            end
            counting = (m_mode == 1) || (m_mode == 3);
            m_ppu = counting && (m_pos % PPU_DIV == 0);
            for (int i = 0; i < 2; i++) begin
                m_cpu[i] = counting && (m_pos == phase[i]);
                if (counting)         m_m2[i] = ((m_pos - phase[i] + CPU_DIV) % CPU_DIV) >= M2_LOW;
                else if (m_mode != 2) m_m2[i] = 0;
                if (m_cpu[i]) m_cyc[i] = m_cyc[i] + 32'd1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk_mst);
        model_update();
        #1;
        cyc_no++;
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("ce_ppu%0d", i), {31'd0, ce_ppu_v[i]}, {31'd0, m_ppu});
            checkOutput($sformatf("ce_cpu%0d", i), {31'd0, ce_cpu_v[i]}, {31'd0, m_cpu[i]});
            checkOutput($sformatf("m2_%0d", i), {31'd0, m2_v[i]}, {31'd0, m_m2[i]});
            checkOutput($sformatf("step_ack%0d", i), {31'd0, step_ack_v[i]}, {31'd0, m_ack});
            checkOutput($sformatf("cpu_cycles%0d", i), cyc_v[i], m_cyc[i]);
        end
        if (ce_ppu_v[0]) n_ppu0++;
        if (ce_cpu_v[0]) n_cpu0++;
        if (ce_cpu_v[1]) n_cpu1++;
        if (!m2_v[0]) n_m2low0++;
        if (step_ack_v[0]) begin
            n_ack++;
            last_ack = cyc_no;
        end
        if (ce_cpu_v[0] && first_ce < 0) first_ce = cyc_no;
        if (ce_ppu_v[0] && first_ppu < 0) first_ppu = cyc_no;
        if (ce_cpu_v[0]) since0 = 0;
        else             since0++;
        if (ce_cpu_v[1] && since0 != 6) ph_bad++;
        if (m2_v[1] != !(since0 >= 6 && since0 <= 10)) ph_bad++;
    endtask

    task automatic applyStimulus(input bit r, input bit lk, input bit rn, input bit st, input int n);
        rst = r; pll_locked = lk; run = rn; step_req = st;
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic relock_check(input string tag);
        int lock_cycle;
        lock_cycle = cyc_no;
        first_ce   = -1;
        first_ppu  = -1;
        applyStimulus(0, 1, 1, 0, 30);
        checkOutput({tag, "_cpu_lat"}, 32'(first_ce - lock_cycle), 32'd18);
        checkOutput({tag, "_ppu_lat"}, 32'(first_ppu - lock_cycle), 32'd18);
    endtask

    initial begin
        int s_ppu, s_cpu0, s_cpu1, s_m2, s_ph, s_ack;
        logic [31:0] s_cyc;
        int req;
        bit run_l;
        int lock_off;

        $display("[TB] nes_clock_sched bench start, debug step build = %0d", DEBUG);

        // Reset with lock low, then a long unlocked period
        applyStimulus(1, 0, 1, 0, 3);
        checkOutput("rst_cpu_cycles", cyc_v[0], 32'd0);
        checkOutput("rst_ce_cpu", {31'd0, ce_cpu_v[0]}, 32'd0);
        applyStimulus(0, 0, 1, 0, 50);
        checkOutput("unlocked_no_ppu", 32'(n_ppu0), 32'd0);

        // Lock gating: first enables exactly 18 clocks after lock rises
        relock_check("lock");

        // Ratio over 100 CPU periods, also checks the CPU_PHASE=6 instance
        s_ppu = n_ppu0; s_cpu0 = n_cpu0; s_cpu1 = n_cpu1; s_m2 = n_m2low0;
        s_ph = ph_bad; s_cyc = cyc_v[0];
        applyStimulus(0, 1, 1, 0, 1200);
        checkOutput("ratio_ppu", 32'(n_ppu0 - s_ppu), 32'd300);
        checkOutput("ratio_cpu", 32'(n_cpu0 - s_cpu0), 32'd100);
        checkOutput("ratio_cycles", cyc_v[0] - s_cyc, 32'd100);
        checkOutput("ratio_m2_low", 32'(n_m2low0 - s_m2), 32'd500);
        checkOutput("ph6_cpu", 32'(n_cpu1 - s_cpu1), 32'd100);
        checkOutput("ph6_align", 32'(ph_bad - s_ph), 32'd0);

`ifdef NES_DEBUG_STEP_EN
        // Pause alignment: drop run while mc = 3
        for (int k = 0; k < 30 && since0 != 3; k++) applyStimulus(0, 1, 1, 0, 1);
        checkOutput("reach_mc3", 32'(since0), 32'd3);
        s_ppu = n_ppu0; s_cpu0 = n_cpu0;
        applyStimulus(0, 1, 0, 0, 8);
        checkOutput("pause_tail_ppu", 32'(n_ppu0 - s_ppu), 32'd2);
        checkOutput("pause_tail_cpu", 32'(n_cpu0 - s_cpu0), 32'd0);
        s_ppu = n_ppu0; s_cpu0 = n_cpu0;
        applyStimulus(0, 1, 0, 0, 10);
        checkOutput("paused_quiet", 32'((n_ppu0 - s_ppu) + (n_cpu0 - s_cpu0)), 32'd0);
        applyStimulus(0, 1, 1, 0, 1);
        checkOutput("resume_cpu", {31'd0, ce_cpu_v[0]}, 32'd1);
        checkOutput("resume_ppu", {31'd0, ce_ppu_v[0]}, 32'd1);

        // Single steps from pause, one extra request issued during a step
        applyStimulus(0, 1, 0, 0, 14);
        s_ack = n_ack; s_cyc = cyc_v[0];
        for (int k = 0; k < 4; k++) begin
            req = cyc_no;
            applyStimulus(0, 1, 0, 1, 1);
            applyStimulus(0, 1, 0, 0, 4);
            applyStimulus(0, 1, 0, (k == 1), 1);
            applyStimulus(0, 1, 0, 0, 14);
            checkOutput($sformatf("step%0d_latency", k), 32'(last_ack - req), 32'd13);
        end
        checkOutput("step_ack_count", 32'(n_ack - s_ack), 32'd4);
        checkOutput("step_cycles", cyc_v[0] - s_cyc, 32'd4);

        // Lock loss five cycles into a step
        s_ack = n_ack;
        applyStimulus(0, 1, 0, 1, 1);
        applyStimulus(0, 1, 0, 0, 5);
`endif
        // Lock loss: enables must be gone from the third clock on
        s_ack = n_ack;
        applyStimulus(0, 0, 1, 0, 2);
        s_ppu = n_ppu0; s_cpu0 = n_cpu0;
        applyStimulus(0, 0, 1, 0, 20);
        checkOutput("lockloss_quiet", 32'((n_ppu0 - s_ppu) + (n_cpu0 - s_cpu0)), 32'd0);
        checkOutput("lockloss_no_ack", 32'(n_ack - s_ack), 32'd0);
        checkOutput("lockloss_m2", {31'd0, m2_v[0]}, 32'd0);
        relock_check("relock");

        // Randomized traffic against the model
        run_l = 1'b1;
        lock_off = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 39) == 0) run_l = ~run_l;
            if (lock_off > 0) lock_off--;
            else if ($urandom_range(0, 499) == 0) lock_off = int'($urandom_range(1, 6));
            applyStimulus(($urandom_range(0, 1499) == 0), (lock_off == 0), run_l,
                          ($urandom_range(0, 14) == 0), 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
